// File: rtl/job_sched.sv
// job_sched: two-requester round-robin job scheduler in front of an accelerator wrapper.
//
// A request is granted in IDLE, acknowledged with a one-cycle req_ready pulse, and its
// descriptor is driven to the wrapper. Valid jobs hold the wrapper in reset for two cycles,
// run until acc_done, and report acc_returnvalue. Jobs with num_read of 0 or above BUF_DEPTH
// skip the wrapper and report an error. Each job ends with one rsp_valid/rsp_ready transfer.
//
// Ports:
//   clk, reset                        clock, asynchronous active-low reset
//   req_valid/req_ready [1:0]         per-requester request / accept pulse
//   req_read_base/req_write_base/req_num_read [127:0]  {req1,req0} 64-bit descriptors
//   rsp_valid/rsp_id/rsp_value/rsp_err/rsp_ready       response channel
//   acc_reset                         active-high reset to the wrapper
//   acc_read_base/acc_write_base/acc_num_read [63:0]   descriptor to the wrapper
//   acc_done/acc_returnvalue          wrapper completion pulse and result
//   timeout_cycles                    watchdog limit (0 = none)
//   busy, jobs_done                   status
//
// Optional feature: define JOB_SCHED_TIMEOUT_EN to enable the RUN-state watchdog.

module job_sched #(
   parameter int unsigned NUM_REQ   = 2,
   parameter int unsigned BUF_DEPTH = 128
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_REQ-1:0]     req_valid,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic [64*NUM_REQ-1:0]  req_read_base,
   input  logic [64*NUM_REQ-1:0]  req_write_base,
   input  logic [64*NUM_REQ-1:0]  req_num_read,
   output logic                   rsp_valid,
   output logic                   rsp_id,
   output logic [31:0]            rsp_value,
   output logic                   rsp_err,
   input  logic                   rsp_ready,
   output logic                   acc_reset,
   output logic [63:0]            acc_read_base,
   output logic [63:0]            acc_write_base,
   output logic [63:0]            acc_num_read,
   input  logic                   acc_done,
   input  logic [31:0]            acc_returnvalue,
   input  logic [31:0]            timeout_cycles,
   output logic                   busy,
   output logic [31:0]            jobs_done
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] ACC_RST = 2'd1;
   localparam logic [1:0] RUN     = 2'd2;
   localparam logic [1:0] RESP    = 2'd3;

   logic [1:0]         state_q, state_d;
   logic               rst_cnt_q, rst_cnt_d;
   logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
   logic               gnt_q, gnt_d;
   logic               last_q, last_d;
   logic [63:0]        rd_q, rd_d;
   logic [63:0]        wr_q, wr_d;
   logic [63:0]        num_q, num_d;
   logic [31:0]        value_q, value_d;
   logic               err_q, err_d;
   logic [31:0]        jobs_q, jobs_d;

   logic               any_valid;
   logic               pick;
   logic [6:0]         sel_off;
   logic               bad_num;

   assign any_valid = |req_valid;
   // Contention goes to the requester not served last; otherwise the lone requester wins.
   assign pick      = (req_valid[0] & req_valid[1]) ? ~last_q : req_valid[1];
   assign sel_off   = {pick, 6'd0};
   assign bad_num   = (num_q == 64'd0) || (num_q > 64'(BUF_DEPTH));

`ifdef JOB_SCHED_TIMEOUT_EN
   logic [31:0] to_cnt_q, to_cnt_d;
   logic        timeout_hit;

   assign timeout_hit = (timeout_cycles != 32'd0) && ((to_cnt_q + 32'd1) >= timeout_cycles);
`else
   logic unused_timeout;

   assign unused_timeout = ^timeout_cycles;
`endif

   always_comb begin
      state_d     = state_q;
      rst_cnt_d   = rst_cnt_q;
      req_ready_d = req_ready_q;
      gnt_d       = gnt_q;
      last_d      = last_q;
      rd_d        = rd_q;
      wr_d        = wr_q;
      num_d       = num_q;
      value_d     = value_q;
      err_d       = err_q;
      jobs_d      = jobs_q;
`ifdef JOB_SCHED_TIMEOUT_EN
      to_cnt_d    = to_cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (req_ready_q != '0) begin
               // Accept pulse is on the wire this cycle; the transfer completes at this edge.
               req_ready_d = '0;
               rst_cnt_d   = 1'b0;
               if (bad_num) begin
                  err_d   = 1'b1;
                  value_d = 32'd0;
                  state_d = RESP;
               end else begin
                  state_d = ACC_RST;
               end
            end else if (any_valid) begin
               req_ready_d       = '0;
               req_ready_d[pick] = 1'b1;
               gnt_d             = pick;
               rd_d              = req_read_base[sel_off +: 64];
               wr_d              = req_write_base[sel_off +: 64];
               num_d             = req_num_read[sel_off +: 64];
            end
         end
         ACC_RST: begin
            if (rst_cnt_q) begin
               state_d = RUN;
`ifdef JOB_SCHED_TIMEOUT_EN
               to_cnt_d = 32'd0;
`endif
            end else begin
               rst_cnt_d = 1'b1;
            end
         end
         RUN: begin
            if (acc_done) begin
               value_d = acc_returnvalue;
               err_d   = 1'b0;
               state_d = RESP;
            end
`ifdef JOB_SCHED_TIMEOUT_EN
            else if (timeout_hit) begin
               value_d = 32'd0;
               err_d   = 1'b1;
               state_d = RESP;
            end else begin
               to_cnt_d = to_cnt_q + 32'd1;
            end
`endif
         end
         RESP: begin
            if (rsp_ready) begin
               jobs_d  = jobs_q + 32'd1;
               last_d  = gnt_q;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         rst_cnt_q   <= 1'b0;
         req_ready_q <= '0;
         gnt_q       <= 1'b0;
         last_q      <= 1'b1;
         rd_q        <= 64'd0;
         wr_q        <= 64'd0;
         num_q       <= 64'd0;
         value_q     <= 32'd0;
         err_q       <= 1'b0;
         jobs_q      <= 32'd0;
`ifdef JOB_SCHED_TIMEOUT_EN
         to_cnt_q    <= 32'd0;
`endif
      end else begin
         state_q     <= state_d;
         rst_cnt_q   <= rst_cnt_d;
         req_ready_q <= req_ready_d;
         gnt_q       <= gnt_d;
         last_q      <= last_d;
         rd_q        <= rd_d;
         wr_q        <= wr_d;
         num_q       <= num_d;
         value_q     <= value_d;
         err_q       <= err_d;
         jobs_q      <= jobs_d;
`ifdef JOB_SCHED_TIMEOUT_EN
         to_cnt_q    <= to_cnt_d;
`endif
      end
   end

   assign req_ready      = req_ready_q;
   assign rsp_valid      = (state_q == RESP);
   assign rsp_id         = gnt_q;
   assign rsp_value      = value_q;
   assign rsp_err        = err_q;
   assign acc_reset      = (state_q != RUN);
   assign acc_read_base  = rd_q;
   assign acc_write_base = wr_q;
   assign acc_num_read   = num_q;
   assign busy           = (state_q != IDLE);
   assign jobs_done      = jobs_q;

endmodule

// File: tb/tb_job_sched.sv
// tb_job_sched: directed self-checking bench for job_sched.
// Scenarios: reset values, single job, round-robin order, bad num_read, watchdog,
// reset in the middle of a job.

module tb_job_sched;

   logic         clk = 1'b0;
   logic         reset;
   logic [1:0]   req_valid;
   logic [1:0]   req_ready;
   logic [127:0] req_read_base, req_write_base, req_num_read;
   logic         rsp_valid, rsp_id, rsp_err, rsp_ready;
   logic [31:0]  rsp_value;
   logic         acc_reset;
   logic [63:0]  acc_read_base, acc_write_base, acc_num_read;
   logic         acc_done;
   logic [31:0]  acc_returnvalue, timeout_cycles;
   logic         busy;
   logic [31:0]  jobs_done;

   int          total = 0;
   int          bad = 0;
   logic [31:0] exp_jobs = 32'd0;

   job_sched #(.NUM_REQ(2), .BUF_DEPTH(128)) dut (
      .clk             (clk),
      .reset           (reset),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_read_base   (req_read_base),
      .req_write_base  (req_write_base),
      .req_num_read    (req_num_read),
      .rsp_valid       (rsp_valid),
      .rsp_id          (rsp_id),
      .rsp_value       (rsp_value),
      .rsp_err         (rsp_err),
      .rsp_ready       (rsp_ready),
      .acc_reset       (acc_reset),
      .acc_read_base   (acc_read_base),
      .acc_write_base  (acc_write_base),
      .acc_num_read    (acc_num_read),
      .acc_done        (acc_done),
      .acc_returnvalue (acc_returnvalue),
      .timeout_cycles  (timeout_cycles),
      .busy            (busy),
      .jobs_done       (jobs_done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_desc(input int idx, input logic [63:0] rd, input logic [63:0] wr,
                           input logic [63:0] num);
      req_read_base[idx*64 +: 64]  = rd;
      req_write_base[idx*64 +: 64] = wr;
      req_num_read[idx*64 +: 64]   = num;
   endtask

   // Returns the first nonzero req_ready within a bounded window, 0 if none.
   task automatic wait_grant(output logic [1:0] got);
      got = 2'b00;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (req_ready != 2'b00) begin
            got = req_ready;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; req_valid = 2'b00; rsp_ready = 1'b0; acc_done = 1'b0;
      acc_returnvalue = 32'd0; timeout_cycles = 32'd0;
      req_read_base = '0; req_write_base = '0; req_num_read = '0;
      #1;
      total++; if (acc_reset !== 1'b1) begin bad++; $display("FAIL rst_acc_reset got=%b exp=1", acc_reset); end
      total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL rst_req_ready got=%b exp=00", req_ready); end
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
      total++; if (rsp_err !== 1'b0 || rsp_id !== 1'b0) begin bad++; $display("FAIL rst_rsp_err_id got=%b%b exp=00", rsp_err, rsp_id); end
      total++; if (rsp_value !== 32'd0) begin bad++; $display("FAIL rst_rsp_value got=%h exp=0", rsp_value); end
      total++; if (acc_num_read !== 64'd0 || acc_read_base !== 64'd0 || acc_write_base !== 64'd0) begin
         bad++; $display("FAIL rst_acc_desc got=%h exp=0", acc_num_read); end
      total++; if (busy !== 1'b0 || jobs_done !== 32'd0) begin bad++; $display("FAIL rst_busy_jobs got=%b/%0d exp=0/0", busy, jobs_done); end
      tick(); tick();
      reset = 1'b1;
      tick();
      total++; if (busy !== 1'b0 || acc_reset !== 1'b1) begin bad++; $display("FAIL rst_release got=%b%b exp=01", busy, acc_reset); end
   endtask

   task automatic test_single();
      logic [1:0] got;
      set_desc(0, 64'h1000, 64'h2000, 64'd16);
      acc_done = 1'b1;  // must be ignored outside RUN
      req_valid = 2'b01;
      wait_grant(got);
      total++; if (got !== 2'b01) begin bad++; $display("FAIL single_grant got=%b exp=01", got); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_pulse got=%b exp=0", busy); end
      req_valid = 2'b00;
      tick();
      total++; if (busy !== 1'b1 || acc_reset !== 1'b1 || req_ready !== 2'b00) begin
         bad++; $display("FAIL single_accrst1 got=%b%b%b exp=110", busy, acc_reset, req_ready); end
      total++; if (acc_read_base !== 64'h1000 || acc_write_base !== 64'h2000 || acc_num_read !== 64'd16) begin
         bad++; $display("FAIL single_desc got=%h/%h/%h exp=1000/2000/10", acc_read_base, acc_write_base, acc_num_read); end
      tick();
      total++; if (acc_reset !== 1'b1) begin bad++; $display("FAIL single_accrst2 got=%b exp=1", acc_reset); end
      tick();
      total++; if (acc_reset !== 1'b0 || rsp_valid !== 1'b0) begin
         bad++; $display("FAIL single_run got=%b%b exp=00", acc_reset, rsp_valid); end
      acc_done = 1'b0;
      for (int i = 0; i < 50; i++) tick();
      total++; if (acc_reset !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL single_wait got=%b%b exp=01", acc_reset, busy); end
      acc_done = 1'b1; acc_returnvalue = 32'h1234;
      tick();
      acc_done = 1'b0;
      total++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_err !== 1'b0) begin
         bad++; $display("FAIL single_rsp got=%b%b%b exp=100", rsp_valid, rsp_id, rsp_err); end
      total++; if (rsp_value !== 32'h1234) begin bad++; $display("FAIL single_value got=%h exp=1234", rsp_value); end
      total++; if (acc_reset !== 1'b1) begin bad++; $display("FAIL single_done_accrst got=%b exp=1", acc_reset); end
      acc_returnvalue = 32'hdead; acc_done = 1'b1;
      tick(); tick(); tick();
      acc_done = 1'b0;
      total++; if (rsp_valid !== 1'b1 || rsp_value !== 32'h1234 || acc_num_read !== 64'd16) begin
         bad++; $display("FAIL single_hold got=%b/%h exp=1/1234", rsp_valid, rsp_value); end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      exp_jobs++;
      total++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || jobs_done !== exp_jobs) begin
         bad++; $display("FAIL single_end got=%b%b/%0d exp=00/%0d", rsp_valid, busy, jobs_done, exp_jobs); end
   endtask

   task automatic test_grant_order();
      logic [1:0] got, exp_g;
      reset = 1'b0; tick(); reset = 1'b1; tick();
      exp_jobs = 32'd0;
      set_desc(0, 64'h100, 64'h200, 64'd1);
      set_desc(1, 64'h300, 64'h400, 64'd128);
      for (int i = 0; i < 4; i++) begin
         exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
         req_valid = 2'b11;
         wait_grant(got);
         total++; if (got !== exp_g) begin bad++; $display("FAIL rr_grant%0d got=%b exp=%b", i, got, exp_g); end
         req_valid = req_valid & ~exp_g;
         tick();
         total++; if (acc_reset !== 1'b1 || req_ready !== 2'b00) begin
            bad++; $display("FAIL rr_accrst1_%0d got=%b%b exp=100", i, acc_reset, req_ready); end
         total++; if (acc_num_read !== (exp_g[1] ? 64'd128 : 64'd1)) begin
            bad++; $display("FAIL rr_num%0d got=%0d", i, acc_num_read); end
         tick();
         total++; if (acc_reset !== 1'b1) begin bad++; $display("FAIL rr_accrst2_%0d got=%b exp=1", i, acc_reset); end
         tick();
         total++; if (acc_reset !== 1'b0) begin bad++; $display("FAIL rr_run%0d got=%b exp=0", i, acc_reset); end
         acc_returnvalue = 32'h100 + i; acc_done = 1'b1;
         tick();
         acc_done = 1'b0;
         total++; if (rsp_valid !== 1'b1 || rsp_id !== exp_g[1] || rsp_value !== 32'h100 + i) begin
            bad++; $display("FAIL rr_rsp%0d got=%b%b/%h exp=1%b/%h", i, rsp_valid, rsp_id, rsp_value, exp_g[1], 32'h100 + i); end
         rsp_ready = 1'b1;
         tick();
         rsp_ready = 1'b0;
         exp_jobs++;
         total++; if (rsp_valid !== 1'b0 || jobs_done !== exp_jobs) begin
            bad++; $display("FAIL rr_end%0d got=%b/%0d exp=0/%0d", i, rsp_valid, jobs_done, exp_jobs); end
      end
      req_valid = 2'b00;
      tick();
   endtask

   task automatic test_bad_num();
      logic [1:0] got;
      logic       rst_low_seen;
      for (int k = 0; k < 2; k++) begin
         rst_low_seen = 1'b0;
         set_desc(1, 64'h500, 64'h600, (k == 0) ? 64'd0 : 64'd129);
         req_valid = 2'b10;
         wait_grant(got);
         total++; if (got !== 2'b10) begin bad++; $display("FAIL bad_grant%0d got=%b exp=10", k, got); end
         req_valid = 2'b00;
         rsp_ready = 1'b1;
         tick();
         if (acc_reset !== 1'b1) rst_low_seen = 1'b1;
         total++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_id !== 1'b1) begin
            bad++; $display("FAIL bad_rsp%0d got=%b%b%b exp=111", k, rsp_valid, rsp_err, rsp_id); end
         total++; if (rsp_value !== 32'd0) begin bad++; $display("FAIL bad_value%0d got=%h exp=0", k, rsp_value); end
         tick();
         rsp_ready = 1'b0;
         if (acc_reset !== 1'b1) rst_low_seen = 1'b1;
         exp_jobs++;
         total++; if (rsp_valid !== 1'b0 || jobs_done !== exp_jobs) begin
            bad++; $display("FAIL bad_end%0d got=%b/%0d exp=0/%0d", k, rsp_valid, jobs_done, exp_jobs); end
         total++; if (rst_low_seen !== 1'b0) begin bad++; $display("FAIL bad_accrst%0d got=low exp=high", k); end
      end
   endtask

   task automatic test_timeout();
      logic [1:0] got;
      logic       early;
      set_desc(0, 64'h700, 64'h800, 64'd16);
      timeout_cycles = 32'd10;
      req_valid = 2'b01;
      wait_grant(got);
      req_valid = 2'b00;
      tick(); tick(); tick();
      total++; if (acc_reset !== 1'b0) begin bad++; $display("FAIL to_run got=%b exp=0", acc_reset); end
`ifdef JOB_SCHED_TIMEOUT_EN
      early = 1'b0;
      for (int c = 1; c < 10; c++) begin
         tick();
         if (rsp_valid !== 1'b0 || acc_reset !== 1'b0) early = 1'b1;
      end
      total++; if (early !== 1'b0) begin bad++; $display("FAIL to_early got=1 exp=0"); end
      tick();
      total++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_value !== 32'd0 || acc_reset !== 1'b1) begin
         bad++; $display("FAIL to_rsp got=%b%b/%h/%b exp=11/0/1", rsp_valid, rsp_err, rsp_value, acc_reset); end
`else
      early = 1'b0;
      for (int c = 0; c < 30; c++) begin
         tick();
         if (rsp_valid !== 1'b0 || busy !== 1'b1 || acc_reset !== 1'b0) early = 1'b1;
      end
      total++; if (early !== 1'b0) begin bad++; $display("FAIL to_nowatchdog got=1 exp=0"); end
      acc_returnvalue = 32'h55; acc_done = 1'b1;
      tick();
      acc_done = 1'b0;
      total++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_value !== 32'h55) begin
         bad++; $display("FAIL to_rsp got=%b%b/%h exp=10/55", rsp_valid, rsp_err, rsp_value); end
`endif
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      exp_jobs++;
      total++; if (jobs_done !== exp_jobs || busy !== 1'b0) begin
         bad++; $display("FAIL to_end got=%0d/%b exp=%0d/0", jobs_done, busy, exp_jobs); end
      timeout_cycles = 32'd0;
   endtask

   task automatic test_reset_mid();
      logic [1:0] got;
      logic       stray;
      set_desc(0, 64'h900, 64'ha00, 64'd16);
      set_desc(1, 64'hb00, 64'hc00, 64'd16);
      req_valid = 2'b01;
      wait_grant(got);
      req_valid = 2'b00;
      tick(); tick(); tick(); tick();
      total++; if (acc_reset !== 1'b0 || jobs_done === 32'd0) begin
         bad++; $display("FAIL mid_pre got=%b/%0d exp=0/nonzero", acc_reset, jobs_done); end
      #2;
      reset = 1'b0;
      #1;
      total++; if (acc_reset !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 2'b00) begin
         bad++; $display("FAIL mid_ctrl got=%b%b%b%b exp=1000", acc_reset, busy, rsp_valid, req_ready); end
      total++; if (acc_read_base !== 64'd0 || acc_num_read !== 64'd0 || jobs_done !== 32'd0) begin
         bad++; $display("FAIL mid_regs got=%h/%h/%0d exp=0/0/0", acc_read_base, acc_num_read, jobs_done); end
      total++; if (rsp_value !== 32'd0 || rsp_err !== 1'b0 || rsp_id !== 1'b0) begin
         bad++; $display("FAIL mid_rsp got=%h/%b%b exp=0/00", rsp_value, rsp_err, rsp_id); end
      tick();
      reset = 1'b1;
      stray = 1'b0;
      acc_done = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (rsp_valid !== 1'b0 || busy !== 1'b0) stray = 1'b1;
      end
      acc_done = 1'b0;
      total++; if (stray !== 1'b0) begin bad++; $display("FAIL mid_abandon got=1 exp=0"); end
      req_valid = 2'b11;
      wait_grant(got);
      total++; if (got !== 2'b01) begin bad++; $display("FAIL mid_lastgrant got=%b exp=01", got); end
      req_valid = 2'b00;
      tick();
   endtask

   initial begin
      test_reset();
      test_single();
      test_grant_order();
      test_bad_num();
      test_timeout();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/job_sched.md
JOB_SCHED -- requirements
Module: job_sched

Interface
REQ-001 The parameter NUM_REQ SHALL default to 2 and is the number of requesters (fixed; round-robin over 2).
REQ-002 The parameter BUF_DEPTH SHALL default to 128 and is the maximum num_read accepted (accelerator buffer depth).
REQ-003 clk  in  1  sole clock; all logic on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 req_valid  in  2  per-requester job request.
REQ-006 req_ready  out  2  one-cycle accept pulse per requester.
REQ-007 req_read_base, req_write_base, req_num_read  in  128 each  {req1,req0} 64-bit descriptors.
REQ-008 rsp_valid  out  1; rsp_id  out  1; rsp_value  out  32; rsp_err  out  1; rsp_ready  in  1  response channel.
REQ-009 acc_reset  out  1  active-high reset to accelerator wrapper.
REQ-010 acc_read_base, acc_write_base, acc_num_read  out  64 each  descriptor to wrapper.
REQ-011 acc_done  in  1; acc_returnvalue  in  32  wrapper completion pulse and result.
REQ-012 timeout_cycles  in  32  watchdog limit; busy  out  1; jobs_done  out  32.

Function
REQ-013 The FSM SHALL have states IDLE, ACC_RST, RUN, RESP; busy=1 in any state except IDLE.
REQ-014 IDLE: acc_reset=1; when any req_valid=1, grant one requester, latch its descriptor, pulse its req_ready for one cycle.
REQ-015 Both valid in same cycle: grant the requester not granted last; after reset, requester 0 wins.
REQ-016 Requester SHALL hold valid and descriptor stable until its req_ready pulse; transfer occurs on valid&ready.
REQ-017 num_read==0 or num_read>BUF_DEPTH: accept, skip accelerator, go RESP with rsp_err=1, rsp_value=0.
REQ-018 Valid job: go to ACC_RST; hold acc_reset=1 for exactly 2 cycles with acc_* descriptor stable, then deassert and enter RUN.
REQ-019 acc_* descriptor outputs SHALL remain stable from ACC_RST entry until RESP exit.
REQ-020 RUN: on acc_done=1, capture acc_returnvalue, assert acc_reset=1, go RESP with rsp_err=0.
REQ-021 acc_done outside RUN SHALL be ignored.
REQ-022 RESP: rsp_valid=1 with rsp_id=granted index; hold all rsp_* until rsp_ready=1; then rsp_valid=0, jobs_done+1 (wraps 2^32-1->0), update last-grant, return to IDLE.
REQ-023 rsp_ready=1 in the same cycle rsp_valid rises completes the transfer in that cycle.
REQ-024 No new request SHALL be accepted while busy=1; req_ready=0 outside IDLE.
REQ-025 Latency: req_ready pulse to acc_reset deassert = 3 cycles; acc_done to rsp_valid = 1 cycle.

Reset
REQ-026 reset=0 SHALL immediately force: state IDLE, acc_reset=1, req_ready=0, rsp_valid=0, rsp_err=0, rsp_id=0, rsp_value=0, acc_* descriptor=0, jobs_done=0, busy=0, last-grant=1.
REQ-027 Reset asserted mid-job SHALL abandon the job with no response issued.

Configuration
REQ-028 Macro JOB_SCHED_TIMEOUT_EN: when defined, a 32-bit counter clears on RUN entry and increments each RUN cycle; reaching timeout_cycles (nonzero) before acc_done ends the job: acc_reset=1, RESP with rsp_err=1, rsp_value=0.
REQ-029 Without JOB_SCHED_TIMEOUT_EN, no counter exists, timeout_cycles is ignored, RUN waits indefinitely; timeout_cycles=0 with macro also means no timeout.

Verification
REQ-030 req0 only, num_read=16, acc_done 50 cycles after acc_reset falls, returnvalue=0x1234 -> one rsp: id=0, value=0x1234, err=0, jobs_done=1.
REQ-031 req0 and req1 valid together, repeated twice -> grant order 0,1,0,1; acc_reset high 2 cycles before each job.
REQ-032 req1 num_read=0, then num_read=129 -> two rsp with err=1, value=0, acc_reset never deasserted.
REQ-033 Macro on, timeout_cycles=10, acc_done never -> rsp err=1 exactly 10 RUN cycles after entry; macro off -> busy stays 1.
REQ-034 reset low during RUN and rsp_ready held low in RESP -> all outputs at REQ-026 values immediately; rsp held stable until rsp_ready.
